// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus responder: nibble FSM states,
// command prefixes, DDRAM window bases and the address stepping helper.
package lcd_pkg;

  typedef enum logic [1:0] {
    M8,
    HI,
    LO
  } rx_mode_e;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [6:0] ROW0_BASE  = 7'h00;
  localparam logic [6:0] ROW1_BASE  = 7'h40;

  // Step over the 80-location two-line DDRAM space (00-27, 40-67).
  function automatic logic [6:0] ddram_next(input logic [6:0] addr, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (addr == 7'h27)      nxt = ROW1_BASE;
      else if (addr == 7'h67) nxt = ROW0_BASE;
      else                    nxt = addr + 7'd1;
    end else begin
      if (addr == ROW0_BASE)      nxt = 7'h67;
      else if (addr == ROW1_BASE) nxt = 7'h27;
      else                        nxt = addr - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_nibble_rx.sv
// Input synchroniser, falling-edge strobe detector and M8/HI/LO nibble assembler.
// cpl_* is the combinational completion (strobe cycle); byte_* is its registered copy.
module lcd_nibble_rx
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_d,
  output logic       cpl_valid,
  output logic       cpl_rs,
  output logic [7:0] cpl_data,
  output logic       byte_valid,
  output logic       byte_rs,
  output logic [7:0] byte_data,
  output logic       rw_err
);

  logic       in_e_q, in_rs_q, in_rw_q;
  logic [3:0] in_d_q;
  logic       e_q, rs_q, rw_q;
  logic [3:0] d_q;

  rx_mode_e   mode_q, mode_d;
  logic [3:0] hi_q, hi_d;
  logic       byte_valid_q, byte_valid_d;
  logic       byte_rs_q, byte_rs_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       rw_err_q, rw_err_d;

  logic strobe, wr_strobe;

  always_comb begin
    strobe    = e_q & ~in_e_q;
    wr_strobe = strobe & ~rw_q;

    mode_d    = mode_q;
    hi_d      = hi_q;
    cpl_valid = 1'b0;
    cpl_rs    = rs_q;
    cpl_data  = {hi_q, d_q};
    rw_err_d  = rw_err_q | (strobe & rw_q);

    case (mode_q)
      M8: begin
        if (wr_strobe) begin
          cpl_valid = 1'b1;
          cpl_data  = {d_q, 4'h0};
          if (!rs_q && d_q == 4'h2) mode_d = HI;
        end
      end
      HI: begin
        if (wr_strobe) begin
          hi_d   = d_q;
          mode_d = LO;
        end
      end
      LO: begin
        if (wr_strobe) begin
          cpl_valid = 1'b1;
          // 0011xxxx is a function set with DL=1: back to 8-bit transfers
          mode_d = (!rs_q && hi_q == 4'h3) ? M8 : HI;
        end
      end
      default: mode_d = M8;
    endcase

    byte_valid_d = cpl_valid;
    byte_rs_d    = cpl_valid ? cpl_rs : byte_rs_q;
    byte_data_d  = cpl_valid ? cpl_data : byte_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_e_q       <= 1'b0;
      in_rs_q      <= 1'b0;
      in_rw_q      <= 1'b0;
      in_d_q       <= '0;
      e_q          <= 1'b0;
      rs_q         <= 1'b0;
      rw_q         <= 1'b0;
      d_q          <= '0;
      mode_q       <= M8;
      hi_q         <= '0;
      byte_valid_q <= 1'b0;
      byte_rs_q    <= 1'b0;
      byte_data_q  <= '0;
      rw_err_q     <= 1'b0;
    end else begin
      in_e_q       <= lcd_e;
      in_rs_q      <= lcd_rs;
      in_rw_q      <= lcd_rw;
      in_d_q       <= lcd_d;
      e_q          <= in_e_q;
      rs_q         <= in_rs_q;
      rw_q         <= in_rw_q;
      d_q          <= in_d_q;
      mode_q       <= mode_d;
      hi_q         <= hi_d;
      byte_valid_q <= byte_valid_d;
      byte_rs_q    <= byte_rs_d;
      byte_data_q  <= byte_data_d;
      rw_err_q     <= rw_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_rs    = byte_rs_q;
  assign byte_data  = byte_data_q;
  assign rw_err     = rw_err_q;

endmodule

// File: rtl/lcd_responder.sv
// Receiving end of the 4-bit character-LCD bus: decodes bytes, keeps the 2x16
// DDRAM window image and emulates the busy flag to check transmitter timing.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int unsigned CMD_BUSY = 1850,
  parameter int unsigned CLR_BUSY = 76000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [3:0]   LCD_D,
  output logic [127:0] row_A,
  output logic [127:0] row_B,
  output logic         byte_valid,
  output logic         byte_rs,
  output logic [7:0]   byte_data,
  output logic         busy,
  output logic         disp_on,
  output logic         timing_err,
  output logic         rw_err
);

  localparam int unsigned CW = $clog2(CLR_BUSY + 1);

  logic         cpl_valid, cpl_rs;
  logic [7:0]   cpl_data;

  logic [127:0] row_a_q, row_a_d;
  logic [127:0] row_b_q, row_b_d;
  logic [6:0]   addr_q, addr_d;
  logic         inc_q, inc_d;
  logic         cg_q, cg_d;
  logic         disp_on_q, disp_on_d;
  logic         timing_err_q, timing_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  lcd_nibble_rx u_rx (
    .clk        (clk),
    .reset      (reset),
    .lcd_e      (LCD_E),
    .lcd_rs     (LCD_RS),
    .lcd_rw     (LCD_RW),
    .lcd_d      (LCD_D),
    .cpl_valid  (cpl_valid),
    .cpl_rs     (cpl_rs),
    .cpl_data   (cpl_data),
    .byte_valid (byte_valid),
    .byte_rs    (byte_rs),
    .byte_data  (byte_data),
    .rw_err     (rw_err)
  );

  // Decoding the unregistered completion lets the rows change on the same
  // edge that raises byte_valid.
  always_comb begin
    row_a_d      = row_a_q;
    row_b_d      = row_b_q;
    addr_d       = addr_q;
    inc_d        = inc_q;
    cg_d         = cg_q;
    disp_on_d    = disp_on_q;
    timing_err_d = timing_err_q;
    cnt_d        = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;

    if (cpl_valid) begin
      if (cnt_q != '0) timing_err_d = 1'b1;
      cnt_d = CW'(CMD_BUSY);
      if (!cpl_rs) begin
        if (cpl_data >= CMD_DDRAM) begin
          addr_d = cpl_data[6:0];
          cg_d   = 1'b0;
        end else if (cpl_data >= CMD_CGRAM) begin
          cg_d = 1'b1;
        end else if (cpl_data >= CMD_FUNC) begin
          // interface width is tracked by the nibble receiver
        end else if (cpl_data >= CMD_SHIFT) begin
          // display/cursor shift is not modelled
        end else if (cpl_data >= CMD_DISP) begin
          disp_on_d = cpl_data[2];
        end else if (cpl_data >= CMD_ENTRY) begin
          inc_d = cpl_data[1];
        end else if (cpl_data >= CMD_HOME) begin
          addr_d = ROW0_BASE;
          cg_d   = 1'b0;
          cnt_d  = CW'(CLR_BUSY);
        end else if (cpl_data == CMD_CLEAR) begin
          row_a_d = {16{CHAR_SPACE}};
          row_b_d = {16{CHAR_SPACE}};
          addr_d  = ROW0_BASE;
          inc_d   = 1'b1;
          cg_d    = 1'b0;
          cnt_d   = CW'(CLR_BUSY);
        end
      end else if (!cg_q) begin
        for (int unsigned i = 0; i < 16; i++) begin
          if (addr_q[3:0] == 4'(i)) begin
            if (addr_q[6:4] == ROW0_BASE[6:4]) row_a_d[8*(15-i) +: 8] = cpl_data;
            if (addr_q[6:4] == ROW1_BASE[6:4]) row_b_d[8*(15-i) +: 8] = cpl_data;
          end
        end
        addr_d = ddram_next(addr_q, inc_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_a_q      <= {16{CHAR_SPACE}};
      row_b_q      <= {16{CHAR_SPACE}};
      addr_q       <= ROW0_BASE;
      inc_q        <= 1'b1;
      cg_q         <= 1'b0;
      disp_on_q    <= 1'b0;
      timing_err_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      row_a_q      <= row_a_d;
      row_b_q      <= row_b_d;
      addr_q       <= addr_d;
      inc_q        <= inc_d;
      cg_q         <= cg_d;
      disp_on_q    <= disp_on_d;
      timing_err_q <= timing_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign row_A      = row_a_q;
  assign row_B      = row_b_q;
  assign busy       = (cnt_q != '0);
  assign disp_on    = disp_on_q;
  assign timing_err = timing_err_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: table of 4-bit bus bytes plus hand-written
// sequences for init, line fill, busy violation, CGRAM drop, RW strobes and reset.
module tb_lcd_responder;
  import lcd_pkg::*;

  localparam int unsigned T_CMD = 40;
  localparam int unsigned T_CLR = 100;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
  logic [3:0]   LCD_D = '0;
  logic [127:0] row_A, row_B;
  logic         byte_valid, byte_rs, busy, disp_on, timing_err, rw_err;
  logic [7:0]   byte_data;

  int total = 0;
  int bad   = 0;

  lcd_responder #(.CMD_BUSY(T_CMD), .CLR_BUSY(T_CLR)) dut (
    .clk        (clk),
    .reset      (reset),
    .LCD_E      (LCD_E),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_D      (LCD_D),
    .row_A      (row_A),
    .row_B      (row_B),
    .byte_valid (byte_valid),
    .byte_rs    (byte_rs),
    .byte_data  (byte_data),
    .busy       (busy),
    .disp_on    (disp_on),
    .timing_err (timing_err),
    .rw_err     (rw_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic rs, input logic rw, input logic [3:0] d);
    @(negedge clk);
    LCD_RS = rs; LCD_RW = rw; LCD_D = d; LCD_E = 1'b1;
    repeat (2) @(negedge clk);
    LCD_E = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    strobe(rs, 1'b0, b[7:4]);
    strobe(rs, 1'b0, b[3:0]);
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] b;
    logic [6:0] addr;
    logic       disp;
  } vec_t;

  vec_t vecs[18];
  logic [127:0] spaces, exp_a, exp_b;
  int n;

  initial begin
    vecs[0]  = '{1'b0, 8'h80, 7'h00, 1'b1};
    vecs[1]  = '{1'b1, 8'h41, 7'h01, 1'b1};
    vecs[2]  = '{1'b0, 8'h08, 7'h01, 1'b0};
    vecs[3]  = '{1'b0, 8'h0C, 7'h01, 1'b1};
    vecs[4]  = '{1'b0, 8'h8F, 7'h0F, 1'b1};
    vecs[5]  = '{1'b1, 8'h44, 7'h10, 1'b1};
    vecs[6]  = '{1'b0, 8'hA7, 7'h27, 1'b1};
    vecs[7]  = '{1'b1, 8'h45, 7'h40, 1'b1};
    vecs[8]  = '{1'b1, 8'h46, 7'h41, 1'b1};
    vecs[9]  = '{1'b0, 8'h04, 7'h41, 1'b1};
    vecs[10] = '{1'b1, 8'h47, 7'h40, 1'b1};
    vecs[11] = '{1'b1, 8'h48, 7'h27, 1'b1};
    vecs[12] = '{1'b0, 8'h80, 7'h00, 1'b1};
    vecs[13] = '{1'b1, 8'h49, 7'h67, 1'b1};
    vecs[14] = '{1'b0, 8'h06, 7'h67, 1'b1};
    vecs[15] = '{1'b1, 8'h4A, 7'h00, 1'b1};
    vecs[16] = '{1'b0, 8'hC5, 7'h45, 1'b1};
    vecs[17] = '{1'b0, 8'h03, 7'h00, 1'b1};
    spaces = {16{8'h20}};

    // reset state
    repeat (3) @(negedge clk);
    check("rst row_A", row_A, spaces);
    check("rst row_B", row_B, spaces);
    check("rst flags", {byte_valid, byte_rs, busy, disp_on, timing_err, rw_err}, '0);
    check("rst byte_data", byte_data, 8'h00);
    check("rst mode", dut.u_rx.mode_q, M8);
    check("rst addr", dut.addr_q, 7'h00);
    reset = 1'b1;
    @(negedge clk);

    // init sequence: 8-bit nibbles 3,3,3,2 then 4-bit bytes
    strobe(1'b0, 1'b0, 4'h3); wait_idle;
    check("m8 byte_data", byte_data, 8'h30);
    strobe(1'b0, 1'b0, 4'h3); wait_idle;
    strobe(1'b0, 1'b0, 4'h3); wait_idle;
    strobe(1'b0, 1'b0, 4'h2); wait_idle;
    check("init mode HI", dut.u_rx.mode_q, HI);
    send_byte(1'b0, 8'h28); wait_idle;
    send_byte(1'b0, 8'h0C); wait_idle;
    send_byte(1'b0, 8'h06); wait_idle;
    send_byte(1'b0, 8'h01); wait_idle;
    check("init mode", dut.u_rx.mode_q, HI);
    check("init disp_on", disp_on, 1'b1);
    check("init row_A", row_A, spaces);
    check("init row_B", row_B, spaces);
    check("init timing_err", timing_err, 1'b0);

    // table-driven bytes in 4-bit mode
    for (int i = 0; i < 18; i++) begin
      send_byte(vecs[i].rs, vecs[i].b);
      check($sformatf("vec%0d valid", i), byte_valid, 1'b1);
      check($sformatf("vec%0d byte", i), {byte_rs, byte_data}, {vecs[i].rs, vecs[i].b});
      @(negedge clk);
      check($sformatf("vec%0d pulse", i), byte_valid, 1'b0);
      check($sformatf("vec%0d addr", i), dut.addr_q, vecs[i].addr);
      check($sformatf("vec%0d disp", i), disp_on, vecs[i].disp);
      wait_idle;
    end
    exp_a = spaces; exp_a[127:120] = 8'h49; exp_a[7:0] = 8'h44;
    exp_b = spaces; exp_b[127:120] = 8'h48; exp_b[119:112] = 8'h47;
    check("tbl row_A", row_A, exp_a);
    check("tbl row_B", row_B, exp_b);
    check("tbl timing_err", timing_err, 1'b0);

    // fill line 1 past its end
    send_byte(1'b0, 8'h01); wait_idle;
    send_byte(1'b0, 8'h80); wait_idle;
    for (int i = 0; i < 17; i++) begin
      send_byte(1'b1, 8'h41); wait_idle;
    end
    check("fill row_A", row_A, {16{8'h41}});
    check("fill addr", dut.addr_q, 7'h11);
    check("fill row_B", row_B, spaces);
    check("fill timing_err", timing_err, 1'b0);

    // clear issued while still busy
    send_byte(1'b0, 8'hC0); wait_idle;
    send_byte(1'b1, 8'h42);
    check("busy row_B", row_B[127:120], 8'h42);
    repeat (10) @(negedge clk);
    send_byte(1'b0, 8'h01);
    check("clr valid", byte_valid, 1'b1);
    check("clr same-cycle rows", {row_A, row_B}, {spaces, spaces});
    check("clr timing_err", timing_err, 1'b1);
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("clr busy cycles", n, T_CLR);

    // CGRAM address drops data until DDRAM set
    send_byte(1'b0, 8'h04); wait_idle;
    send_byte(1'b0, 8'h40); wait_idle;
    send_byte(1'b1, 8'h33); wait_idle;
    check("cg drop row_A", row_A, spaces);
    check("cg drop addr", dut.addr_q, 7'h00);
    send_byte(1'b0, 8'h80); wait_idle;
    send_byte(1'b1, 8'h5A); wait_idle;
    check("cg row_A[0]", row_A[127:120], 8'h5A);
    check("dec wrap addr", dut.addr_q, 7'h67);

    // read strobe is flagged and does not consume a nibble
    strobe(1'b0, 1'b1, 4'hF);
    check("rw_err", rw_err, 1'b1);
    send_byte(1'b0, 8'h8A); wait_idle;
    check("rw byte", byte_data, 8'h8A);
    check("rw addr", dut.addr_q, 7'h0A);

    // reset between high and low nibble
    strobe(1'b1, 1'b0, 4'h7);
    check("mid mode LO", dut.u_rx.mode_q, LO);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("mid rst rows", {row_A, row_B}, {spaces, spaces});
    check("mid rst flags", {byte_valid, byte_rs, byte_data, busy, disp_on, timing_err, rw_err}, '0);
    check("mid rst mode", dut.u_rx.mode_q, M8);
    reset = 1'b1;
    @(negedge clk);
    strobe(1'b1, 1'b0, 4'h4);
    check("post rst byte", {byte_valid, byte_rs, byte_data}, {2'b11, 8'h40});
    check("post rst row_A", row_A[127:120], 8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
